// File: rtl/subcode_rx.sv
// Q-subcode link receiver: 8N1 UART deserialiser that assembles 12-byte Q blocks
// and checks the CRC-16 (0x1021, init 0) carried inverted in bytes 10-11.
module subcode_rx #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned GAP_BITS = 20
) (
    input  logic        CLK50MHZ,
    input  logic        rst_n,
    input  logic        RxI,
    output logic [95:0] qBits,
    output logic        qValid,
    output logic        crcOk,
    output logic        frameErr,
    output logic        syncErr
);

    localparam int unsigned CNT_W   = $clog2(BAUD_DIV);
    localparam int unsigned GAP_LIM = GAP_BITS * BAUD_DIV;
    localparam int unsigned GAP_W   = $clog2(GAP_LIM);

    // Counters run down to zero, so loads are one less than the interval.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_LIM - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} stateT;

    stateT            state;
    stateT            stateNext;
    logic             rxMeta;
    logic             rxSync;
    logic             rxPrev;
    logic [CNT_W-1:0] baudCnt;
    logic [2:0]       bitCnt;
    logic [7:0]       shReg;
    logic [GAP_W-1:0] gapCnt;
    logic [3:0]       byteIdx;
    logic [15:0]      crc;
    logic [95:0]      asmBits;

    logic fall;
    logic tick;
    logic startBit;
    logic counting;
    logic dataTick;
    logic byteDone;
    logic badStop;
    logic blockDone;
    logic gapFire;

    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    assign fall = rxPrev & ~rxSync;
    assign tick = (baudCnt == '0);

    // Two-flop synchroniser plus previous-sample for edge detection.
    always_ff @(posedge CLK50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= RxI;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    always_ff @(posedge CLK50MHZ or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (fall) stateNext = START;
            START:   if (tick) stateNext = rxSync ? IDLE : DATA;
            DATA:    if (tick && bitCnt == 3'd7) stateNext = STOP;
            STOP:    if (tick) stateNext = rxSync ? IDLE : BREAK;
            BREAK:   if (rxSync) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        startBit  = (state == IDLE) && fall;
        counting  = (state == START) || (state == DATA) || (state == STOP);
        dataTick  = (state == DATA) && tick;
        byteDone  = (state == STOP) && tick && rxSync;
        badStop   = (state == STOP) && tick && !rxSync;
        blockDone = byteDone && (byteIdx == 4'd11);
        gapFire   = (state == IDLE) && (byteIdx != 4'd0) && !fall && (gapCnt == GAP_LAST);
    end

    // Bit timing and shift register.
    always_ff @(posedge CLK50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            baudCnt <= '0;
            bitCnt  <= 3'd0;
            shReg   <= 8'h00;
        end else begin
            if (startBit)      baudCnt <= HALF_LOAD;
            else if (counting) baudCnt <= tick ? FULL_LOAD : baudCnt - CNT_W'(1);
            if (startBit)      bitCnt <= 3'd0;
            else if (dataTick) bitCnt <= bitCnt + 3'd1;
            if (dataTick)      shReg <= {rxSync, shReg[7:1]};
        end
    end

    // Inter-byte gap watchdog; only armed inside a partially received block.
    always_ff @(posedge CLK50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            gapCnt <= '0;
        end else if (state != IDLE || byteIdx == 4'd0 || fall || gapFire) begin
            gapCnt <= '0;
        end else begin
            gapCnt <= gapCnt + GAP_W'(1);
        end
    end

    // Block assembly, running CRC and result/strobe registers.
    always_ff @(posedge CLK50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            byteIdx  <= 4'd0;
            crc      <= 16'h0000;
            asmBits  <= '0;
            qBits    <= '0;
            crcOk    <= 1'b0;
            qValid   <= 1'b0;
            frameErr <= 1'b0;
            syncErr  <= 1'b0;
        end else begin
            qValid   <= blockDone;
            frameErr <= badStop;
            syncErr  <= gapFire;
            if (badStop || gapFire) begin
                byteIdx <= 4'd0;
                crc     <= 16'h0000;
            end else if (byteDone) begin
                asmBits <= {asmBits[87:0], shReg};
                if (blockDone) begin
                    byteIdx <= 4'd0;
                    crc     <= 16'h0000;
                    qBits   <= {asmBits[87:0], shReg};
                    crcOk   <= ({asmBits[7:0], shReg} == ~crc);
                end else begin
                    byteIdx <= byteIdx + 4'd1;
                    if (byteIdx <= 4'd9) crc <= crcByte(crc, shReg);
                end
            end
        end
    end

endmodule

// File: tb/tb_subcode_rx.sv
// Directed bench for subcode_rx: table of Q blocks sent serially, plus
// hand-written frame-error, gap-timeout, glitch and mid-block reset sequences.
module tb_subcode_rx;

    localparam int unsigned BAUD   = 16;
    localparam int unsigned GAP    = 20;
    localparam int          CLK_NS = 10;
    localparam int          NOM_NS = BAUD * CLK_NS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RxI;
    logic [95:0] qBits;
    logic        qValid;
    logic        crcOk;
    logic        frameErr;
    logic        syncErr;

    int errors = 0;
    int checks = 0;
    int qvCnt = 0;
    int feCnt = 0;
    int seCnt = 0;
    int multiCnt = 0;

    typedef struct {
        logic [95:0] data;
        int          mode;   // 0 raw, 1 good trailer, 2 trailer bit flipped, 3 data bit flipped
        logic        expOk;
    } vecT;

    vecT vecs[7];
    int  skew[3];

    subcode_rx #(.BAUD_DIV(BAUD), .GAP_BITS(GAP)) dut (
        .CLK50MHZ(clk),
        .rst_n(rst_n),
        .RxI(RxI),
        .qBits(qBits),
        .qValid(qValid),
        .crcOk(crcOk),
        .frameErr(frameErr),
        .syncErr(syncErr)
    );

    always #(CLK_NS / 2) clk = ~clk;

    always @(negedge clk) begin
        if (qValid)   qvCnt++;
        if (frameErr) feCnt++;
        if (syncErr)  seCnt++;
        if (int'(qValid) + int'(frameErr) + int'(syncErr) > 1) multiCnt++;
    end

    function automatic logic [15:0] refCrc(input logic [95:0] blk);
        logic [15:0] c;
        c = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            c = c ^ {blk[95 - 8 * k -: 8], 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit, input int bitNs);
        RxI = 1'b0;
        #(bitNs);
        for (int i = 0; i < 8; i++) begin
            RxI = b[i];
            #(bitNs);
        end
        RxI = stopBit;
        #(bitNs);
        RxI = 1'b1;
    endtask

    task automatic sendBytes(input logic [95:0] blk, input int first, input int last, input int bitNs);
        for (int k = first; k <= last; k++) sendByte(blk[95 - 8 * k -: 8], 1'b1, bitNs);
    endtask

    task automatic runBlock(input string name, input logic [95:0] blk, input logic expOk, input int bitNs);
        int qv0;
        int fe0;
        int se0;
        qv0 = qvCnt;
        fe0 = feCnt;
        se0 = seCnt;
        sendBytes(blk, 0, 11, bitNs);
        #(2 * bitNs);
        check({name, " qValid count"}, 96'(qvCnt - qv0), 96'd1);
        check({name, " qBits"}, qBits, blk);
        check({name, " crcOk"}, 96'(crcOk), 96'(expOk));
        check({name, " no error strobes"}, 96'((feCnt - fe0) + (seCnt - se0)), 96'd0);
    endtask

    initial begin
        logic [95:0] blk;
        logic [95:0] blk2;
        int qv0;
        int fe0;
        int se0;

        vecs[0] = '{96'h0000_0000_0000_0000_0000_FFFF, 0, 1'b1};
        vecs[1] = '{96'h0100_0000_0000_0000_0000_FFFF, 0, 1'b0};
        vecs[2] = '{96'h0100_0000_0000_0000_0000_0000, 1, 1'b1};
        vecs[3] = '{96'h3132_3334_3536_3738_3900_0000, 1, 1'b1};
        vecs[4] = '{96'hFFFF_FFFF_FFFF_FFFF_FFFF_0000, 1, 1'b1};
        vecs[5] = '{96'hA55A_0FF0_1234_5678_9ABC_0000, 2, 1'b0};
        vecs[6] = '{96'hDEAD_BEEF_CAFE_F00D_0102_0000, 3, 1'b0};
        skew[0] = NOM_NS;
        skew[1] = 157;
        skew[2] = 163;

        rst_n = 1'b0;
        RxI   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset qBits", qBits, 96'd0);
        check("reset crcOk", 96'(crcOk), 96'd0);
        check("reset qValid", 96'(qValid), 96'd0);
        check("reset frameErr", 96'(frameErr), 96'd0);
        check("reset syncErr", 96'(syncErr), 96'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            blk = vecs[i].data;
            case (vecs[i].mode)
                1: blk[15:0] = ~refCrc(blk);
                2: blk[15:0] = ~refCrc(blk) ^ 16'h0100;
                3: begin
                    blk[15:0] = ~refCrc(blk);
                    blk[60]   = ~blk[60];
                end
                default: ;
            endcase
            runBlock($sformatf("vec%0d", i), blk, vecs[i].expOk, skew[i % 3]);
        end

        for (int r = 0; r < 3; r++) begin
            blk = {$urandom, $urandom, $urandom};
            blk[15:0] = ~refCrc(blk);
            runBlock($sformatf("rand%0d", r), blk, 1'b1, skew[r]);
        end

        // Byte 3 with a low stop bit aborts the block.
        blk = 96'h1122_3344_5566_7788_99AA_0000;
        blk[15:0] = ~refCrc(blk);
        qv0 = qvCnt;
        fe0 = feCnt;
        sendBytes(blk, 0, 2, NOM_NS);
        sendByte(blk[71:64], 1'b0, NOM_NS);
        #(2 * NOM_NS);
        check("frame frameErr count", 96'(feCnt - fe0), 96'd1);
        check("frame no qValid", 96'(qvCnt - qv0), 96'd0);
        runBlock("after frame", blk, 1'b1, NOM_NS);

        // Five bytes then a long idle trips the gap watchdog.
        qv0 = qvCnt;
        se0 = seCnt;
        sendBytes(96'hEEEE_EEEE_EE00_0000_0000_0000, 0, 4, NOM_NS);
        #(21 * NOM_NS);
        check("gap syncErr count", 96'(seCnt - se0), 96'd1);
        check("gap no qValid", 96'(qvCnt - qv0), 96'd0);
        blk = 96'h0F1E_2D3C_4B5A_6978_8796_0000;
        blk[15:0] = ~refCrc(blk);
        runBlock("after gap", blk, 1'b1, NOM_NS);

        // Short low glitch must not start a byte.
        qv0 = qvCnt;
        fe0 = feCnt;
        se0 = seCnt;
        RxI = 1'b0;
        #(BAUD / 4 * CLK_NS);
        RxI = 1'b1;
        #(2 * NOM_NS);
        check("glitch no qValid", 96'(qvCnt - qv0), 96'd0);
        check("glitch no frameErr", 96'(feCnt - fe0), 96'd0);
        check("glitch no syncErr", 96'(seCnt - se0), 96'd0);

        // Reset in the middle of byte 6, then a fresh block.
        sendBytes(blk, 0, 5, NOM_NS);
        RxI = 1'b0;
        #(NOM_NS);
        RxI = 1'b1;
        #(NOM_NS);
        RxI = 1'b0;
        #(NOM_NS / 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset qBits cleared", qBits, 96'd0);
        check("midreset crcOk cleared", 96'(crcOk), 96'd0);
        repeat (3) @(negedge clk);
        RxI   = 1'b1;
        rst_n = 1'b1;
        #(2 * NOM_NS);
        blk2 = 96'h5A5A_C3C3_0001_0203_0405_0000;
        blk2[15:0] = ~refCrc(blk2);
        qv0 = qvCnt;
        sendBytes(blk2, 0, 10, NOM_NS);
        #(2 * NOM_NS);
        check("post-reset 11 bytes no qValid", 96'(qvCnt - qv0), 96'd0);
        check("post-reset qBits still 0", qBits, 96'd0);
        check("post-reset crcOk still 0", 96'(crcOk), 96'd0);
        sendBytes(blk2, 11, 11, NOM_NS);
        #(2 * NOM_NS);
        check("post-reset qValid count", 96'(qvCnt - qv0), 96'd1);
        check("post-reset qBits", qBits, blk2);
        check("post-reset crcOk", 96'(crcOk), 96'd1);

        check("strobe exclusivity", 96'(multiCnt), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/subcode_rx.md
# subcode_rx

UART receiver for the Q-subcode link. It is the host-side counterpart of the subcode transmitter. The block deserialises 8N1 bytes at `CLK50MHZ`, assembles them into 12-byte Q blocks, and checks the CRC-16 carried in bytes 10–11. It then presents the 96-bit block with a one-cycle valid strobe. It sits between the serial input pin and any consumer of decoded Q data (track/index/time display, seek logic).

## Interface
- `BAUD_DIV`, default 434: clocks per bit (50 MHz / 115200); must be ≥ 16.
- `GAP_BITS`, default 20: idle bit-times that abort a partially received block.
- `CLK50MHZ`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `RxI`  in  1  serial input, idle high, asynchronous to the clock.
- `qBits`  out  96  last completed block; first received byte in [95:88], last in [7:0].
- `qValid`  out  1  one-cycle strobe: `qBits`/`crcOk` just updated.
- `crcOk`  out  1  CRC result for the current `qBits`.
- `frameErr`  out  1  one-cycle strobe: stop bit sampled low.
- `syncErr`  out  1  one-cycle strobe: partial block discarded by gap timeout.

## Operation
- Reset values:
  - Outputs: `qBits`=0, `crcOk`=0, `qValid`/`frameErr`/`syncErr`=0.
  - Internal: byte index=0, CRC=0, FSM=IDLE.
- `RxI` passes through a 2-flop synchroniser; all references below are to the synchronised signal.
- Bit FSM, with a bit counter and a baud counter of width ceil(log2(`BAUD_DIV`)):
  - **IDLE**: on a falling edge, go to START and load the baud counter with `BAUD_DIV`/2.
  - **START**: at terminal count, sample. If the sample is 1, treat it as a glitch and return to IDLE with no strobe. If 0, go to DATA and reload the counter with `BAUD_DIV`.
  - **DATA**: sample 8 bits at mid-bit, LSB first, into a shift register. Go to STOP after bit 7.
  - **STOP**: sample. If 1, the byte is accepted. If 0, pulse `frameErr`, discard the partial block (byte index=0, CRC=0), and go to BREAK.
  - **BREAK**: wait until the line is sampled high, then go to IDLE.
- On byte acceptance at byte index k:
  - Store the byte into assembly slot k.
  - For k ≤ 9, update CRC-16, polynomial 0x1021, init 0x0000, bits processed MSB first. Any pipelined form is allowed provided it completes before the next stop-bit sample.
  - For k = 11, the block completes:
    - `qBits` ← assembled block.
    - `crcOk` ← (bytes 10–11 as a 16-bit value, byte 10 high) == ~CRC.
    - Pulse `qValid`.
    - Reset byte index and CRC to 0.
- Gap counter:
  - Counts clocks while in IDLE with byte index ≠ 0; cleared on any falling edge.
  - At `GAP_BITS`×`BAUD_DIV` clocks: pulse `syncErr`, byte index=0, CRC=0.
  - Never fires when byte index = 0.
- `qBits`/`crcOk` hold between `qValid` strobes. A bad CRC still updates `qBits` and pulses `qValid`, with `crcOk`=0.

## Timing
- Sampling: mid-bit, at `BAUD_DIV`/2 clocks after the synchronised falling edge, then every `BAUD_DIV` clocks.
- Input latency: 2 clocks from `RxI` to the synchroniser output.
- `qValid`: asserted exactly 1 clock after the stop-bit sample of byte 11, high for 1 clock. `qBits` and `crcOk` change on the same edge `qValid` rises.
- `frameErr`: asserted the clock after the bad stop sample.
- `syncErr`: asserted the clock after the gap counter reaches terminal count.
- Strobe exclusivity: at most one of `qValid`/`frameErr`/`syncErr` is high in any cycle.
- Back-to-back bytes: a start bit may begin in the same cycle as STOP completes. IDLE must detect a falling edge occurring half a bit after the stop sample.
- Reset mid-byte or mid-block: all state clears immediately. The next valid start bit after release begins byte 0.
- A falling edge during STOP/DATA is not a start; only IDLE detects starts.

## Test plan
- Ten 0x00 bytes, then 0xFF, 0xFF at 115200 baud: expect `qValid` once, `qBits`=96'h0000_0000_0000_0000_0000_FFFF, `crcOk`=1.
- 0x01, nine 0x00, then 0xFF, 0xFF: expect `qValid`, `qBits`[95:88]=8'h01, `crcOk`=0. Then send a correct block (bytes 10–11 = ~CRC from the reference model): expect `crcOk`=1.
- Byte 3 sent with stop bit low: expect `frameErr` pulse and no `qValid`. After line idle, a full valid block is accepted with `crcOk`=1 and correct `qBits`.
- 5 bytes, then idle for 21 bit-times: expect `syncErr` pulse. Then 12 valid bytes: expect a single `qValid` with only those 12 bytes in `qBits`.
- `RxI` low pulse of `BAUD_DIV`/4 clocks: expect no strobe, FSM back in IDLE. `rst_n` low during byte 6 for 3 clocks, then a fresh block: expect `qValid` only after 12 more bytes, with outputs 0 until then.
- Randomised blocks, back-to-back with zero inter-byte gap, ±2% baud skew: every block yields exactly one `qValid` matching the reference model.
